// File: rtl/pcpi_pkg.sv
// PCPI dispatch shared types.
// Decode constants, unit select and FSM states.
package pcpi_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_M,
    SEL_C
  } sel_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_e;

endpackage

// File: rtl/pcpi_decode.sv
// PCPI instruction decoder.
// Picks the coprocessor unit that claims an instruction.
module pcpi_decode
  import pcpi_pkg::*;
(
  input  logic [31:0] insn,
  input  logic [6:0]  custom_opcode,
  output sel_e        sel
);

  logic is_m;
  logic is_c;
  logic unused_bits;

  assign is_m = (insn[6:0] == OPCODE_OP) &&
                (insn[31:25] == FUNCT7_MULDIV);
  assign is_c = (insn[6:0] == custom_opcode) && !is_m;
  assign unused_bits = ^insn[24:7];

  // one-hot claim to unit select
  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      is_m:    sel = SEL_M;
      is_c:    sel = SEL_C;
      default: sel = SEL_NONE;
    endcase
  end

endmodule

// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: routes core requests to M / custom unit.
// Registered response, watchdog abort, no re-issue while retiring.
module pcpi_dispatch
  import pcpi_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [6:0] CUSTOM_OPCODE  = 7'b0001011
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_busy,
  input  logic        m_ready,
  output logic        c_valid,
  input  logic        c_wr,
  input  logic [31:0] c_rd,
  input  logic        c_busy,
  input  logic        c_ready,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state;
  state_e        state_n;
  sel_e          sel_d;
  sel_e          sel_q;
  sel_e          sel_n;
  logic [CW-1:0] cnt;
  logic          take;
  logic          fin;
  logic          fin_wr;
  logic [31:0]   fin_rd;
  logic          tmo;
  logic          u_ready;
  logic          u_wr;
  logic [31:0]   u_rd;
  logic          unused_busy;

  assign unused_busy = m_busy ^ c_busy;

  pcpi_decode u_dec (
    .insn          (pcpi_insn),
    .custom_opcode (CUSTOM_OPCODE),
    .sel           (sel_d)
  );

  assign u_ready = (sel_q == SEL_M) ? m_ready : c_ready;
  assign u_wr    = (sel_q == SEL_M) ? m_wr    : c_wr;
  assign u_rd    = (sel_q == SEL_M) ? m_rd    : c_rd;
  assign sel_n   = take ? sel_d : sel_q;

  // next state; abort beats ready, ready beats timeout
  always_comb begin
    state_n = state;
    take    = 1'b0;
    fin     = 1'b0;
    fin_wr  = 1'b0;
    fin_rd  = '0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pcpi_valid && sel_d != SEL_NONE) begin
          state_n = BUSY;
          take    = 1'b1;
        end
      end
      BUSY: begin
        if (!pcpi_valid) begin
          state_n = IDLE;
        end else if (u_ready) begin
          state_n = DRAIN;
          fin     = 1'b1;
          fin_wr  = u_wr;
          fin_rd  = u_rd;
        end else if (cnt >= T_LAST) begin
          state_n = DRAIN;
          fin     = 1'b1;
          tmo     = 1'b1;
        end
      end
      DRAIN: begin
        if (!pcpi_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, operand latch and saturating busy counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      sel_q         <= SEL_NONE;
      cnt           <= '0;
      m_instruction <= '0;
      m_rs1         <= '0;
      m_rs2         <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        sel_q         <= sel_d;
        cnt           <= '0;
        m_instruction <= pcpi_insn;
        m_rs1         <= pcpi_rs1;
        m_rs2         <= pcpi_rs2;
      end else if (state == BUSY && cnt != T_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // registered core/unit handshake and sticky watchdog flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid     <= 1'b0;
      c_valid     <= 1'b0;
      pcpi_wait   <= 1'b0;
      pcpi_ready  <= 1'b0;
      pcpi_wr     <= 1'b0;
      pcpi_rd     <= '0;
      err_timeout <= 1'b0;
    end else begin
      m_valid    <= (state_n == BUSY) && (sel_n == SEL_M);
      c_valid    <= (state_n == BUSY) && (sel_n == SEL_C);
      pcpi_wait  <= (state_n == BUSY);
      pcpi_ready <= fin;
      pcpi_wr    <= fin_wr;
      pcpi_rd    <= fin_rd;
      if (tmo) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed bench for pcpi_dispatch.
// Hand-computed expectations, TIMEOUT_CYCLES = 8.
module tb_pcpi_dispatch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        m_valid;
  logic [31:0] m_instruction;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic        m_wr;
  logic [31:0] m_rd;
  logic        m_busy;
  logic        m_ready;
  logic        c_valid;
  logic        c_wr;
  logic [31:0] c_rd;
  logic        c_busy;
  logic        c_ready;
  logic        err_timeout;

  int n_vec = 0;
  int n_err = 0;
  int n_rdy;
  int n_wait;
  int n_mup;
  int n_cup;
  logic m_prev;
  logic c_prev;

  localparam logic [31:0] MUL  = 32'h02B50533;
  localparam logic [31:0] DIV  = 32'h02B54533;
  localparam logic [31:0] ADD  = 32'h00B50533;
  localparam logic [31:0] CUST = 32'h1234500B;

  always #5 clk = ~clk;

  pcpi_dispatch #(
    .TIMEOUT_CYCLES (8),
    .CUSTOM_OPCODE  (7'b0001011)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pcpi_valid    (pcpi_valid),
    .pcpi_insn     (pcpi_insn),
    .pcpi_rs1      (pcpi_rs1),
    .pcpi_rs2      (pcpi_rs2),
    .pcpi_wr       (pcpi_wr),
    .pcpi_rd       (pcpi_rd),
    .pcpi_wait     (pcpi_wait),
    .pcpi_ready    (pcpi_ready),
    .m_valid       (m_valid),
    .m_instruction (m_instruction),
    .m_rs1         (m_rs1),
    .m_rs2         (m_rs2),
    .m_wr          (m_wr),
    .m_rd          (m_rd),
    .m_busy        (m_busy),
    .m_ready       (m_ready),
    .c_valid       (c_valid),
    .c_wr          (c_wr),
    .c_rd          (c_rd),
    .c_busy        (c_busy),
    .c_ready       (c_ready),
    .err_timeout   (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (pcpi_ready) n_rdy++;
    if (pcpi_wait) n_wait++;
    if (m_valid && !m_prev) n_mup++;
    if (c_valid && !c_prev) n_cup++;
    m_prev = m_valid;
    c_prev = c_valid;
  endtask

  task automatic clr();
    n_rdy  = 0;
    n_wait = 0;
    n_mup  = 0;
    n_cup  = 0;
    m_prev = m_valid;
    c_prev = c_valid;
  endtask

  task automatic unit_idle();
    m_ready = 1'b0;
    m_wr    = 1'b0;
    m_rd    = '0;
    c_ready = 1'b0;
    c_wr    = 1'b0;
    c_rd    = '0;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, ".wait"},  32'(pcpi_wait), 0);
    chk({tag, ".ready"}, 32'(pcpi_ready), 0);
    chk({tag, ".wr"},    32'(pcpi_wr), 0);
    chk({tag, ".rd"},    pcpi_rd, 0);
    chk({tag, ".mv"},    32'(m_valid), 0);
    chk({tag, ".cv"},    32'(c_valid), 0);
    chk({tag, ".insn"},  m_instruction, 0);
    chk({tag, ".rs1"},   m_rs1, 0);
    chk({tag, ".rs2"},   m_rs2, 0);
    chk({tag, ".err"},   32'(err_timeout), 0);
  endtask

  task automatic issue(input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b);
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
  endtask

  initial begin
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    m_busy     = 1'b0;
    c_busy     = 1'b0;
    unit_idle();
    m_prev = 1'b0;
    c_prev = 1'b0;
    cyc();
    cyc();
    zero_chk("rst");
    resetn = 1'b1;
    cyc();

    // MUL, M unit ready in cycle 3
    clr();
    issue(MUL, 7, 6);
    cyc();
    chk("mul.c1.mv", 32'(m_valid), 1);
    chk("mul.c1.wait", 32'(pcpi_wait), 1);
    chk("mul.c1.insn", m_instruction, MUL);
    chk("mul.c1.rs1", m_rs1, 7);
    chk("mul.c1.rs2", m_rs2, 6);
    m_busy = 1'b1;
    cyc();
    c_ready = 1'b1;
    c_rd    = 32'h0BAD0BAD;
    c_wr    = 1'b1;
    chk("mul.c2.ready", 32'(pcpi_ready), 0);
    cyc();
    c_ready = 1'b0;
    chk("mul.c3.ready", 32'(pcpi_ready), 0);
    m_ready = 1'b1;
    m_rd    = 42;
    m_wr    = 1'b1;
    cyc();
    unit_idle();
    m_busy = 1'b0;
    chk("mul.c4.ready", 32'(pcpi_ready), 1);
    chk("mul.c4.rd", pcpi_rd, 42);
    chk("mul.c4.wr", 32'(pcpi_wr), 1);
    chk("mul.c4.mv", 32'(m_valid), 0);
    chk("mul.c4.wait", 32'(pcpi_wait), 0);
    pcpi_valid = 1'b0;
    cyc();
    chk("mul.c5.ready", 32'(pcpi_ready), 0);
    chk("mul.nrdy", n_rdy, 1);
    chk("mul.ncv", n_cup, 0);
    cyc();

    // custom unit answers in cycle 1, M ready ignored
    clr();
    issue(CUST, 32'h11, 32'h22);
    cyc();
    chk("cus.c1.cv", 32'(c_valid), 1);
    chk("cus.c1.insn", m_instruction, CUST);
    c_ready = 1'b1;
    c_rd    = 32'hDEADBEEF;
    c_wr    = 1'b1;
    m_ready = 1'b1;
    m_rd    = 32'h12345678;
    cyc();
    unit_idle();
    chk("cus.c2.ready", 32'(pcpi_ready), 1);
    chk("cus.c2.rd", pcpi_rd, 32'hDEADBEEF);
    chk("cus.c2.wr", 32'(pcpi_wr), 1);
    chk("cus.c2.cv", 32'(c_valid), 0);
    pcpi_valid = 1'b0;
    cyc();
    chk("cus.nmv", n_mup, 0);
    chk("cus.nrdy", n_rdy, 1);
    cyc();

    // unclaimed ADD left for the core to trap
    clr();
    issue(ADD, 1, 2);
    repeat (100) cyc();
    chk("add.nrdy", n_rdy, 0);
    chk("add.nwait", n_wait, 0);
    chk("add.nissue", n_mup + n_cup, 0);
    pcpi_valid = 1'b0;
    cyc();

    // watchdog, unit never ready
    clr();
    issue(DIV, 9, 3);
    m_rd = 32'hFFFF0000;
    m_wr = 1'b1;
    repeat (8) cyc();
    chk("tmo.c8.ready", 32'(pcpi_ready), 0);
    chk("tmo.c8.err", 32'(err_timeout), 0);
    cyc();
    chk("tmo.c9.ready", 32'(pcpi_ready), 1);
    chk("tmo.c9.wr", 32'(pcpi_wr), 0);
    chk("tmo.c9.rd", pcpi_rd, 0);
    chk("tmo.c9.err", 32'(err_timeout), 1);
    chk("tmo.c9.mv", 32'(m_valid), 0);
    unit_idle();
    pcpi_valid = 1'b0;
    repeat (3) cyc();
    chk("tmo.nrdy", n_rdy, 1);
    chk("tmo.hold", 32'(err_timeout), 1);

    // core abort in cycle 3 coinciding with unit ready
    clr();
    issue(MUL, 5, 5);
    cyc();
    cyc();
    cyc();
    pcpi_valid = 1'b0;
    m_ready    = 1'b1;
    m_rd       = 25;
    m_wr       = 1'b1;
    cyc();
    unit_idle();
    chk("abt.c4.mv", 32'(m_valid), 0);
    chk("abt.c4.wait", 32'(pcpi_wait), 0);
    chk("abt.c4.ready", 32'(pcpi_ready), 0);
    repeat (3) cyc();
    chk("abt.nrdy", n_rdy, 0);
    chk("abt.err", 32'(err_timeout), 1);

    // two DIVs, valid held into DRAIN with unit ready stuck high
    clr();
    issue(DIV, 100, 7);
    m_ready = 1'b1;
    m_rd    = 14;
    m_wr    = 1'b1;
    cyc();
    chk("b2b.c1.mv", 32'(m_valid), 1);
    cyc();
    chk("b2b.c2.ready", 32'(pcpi_ready), 1);
    chk("b2b.c2.rd", pcpi_rd, 14);
    cyc();
    chk("b2b.c3.ready", 32'(pcpi_ready), 0);
    chk("b2b.c3.mv", 32'(m_valid), 0);
    pcpi_valid = 1'b0;
    cyc();
    issue(DIV, 9, 3);
    m_rd = 3;
    cyc();
    chk("b2b.c5.mv", 32'(m_valid), 1);
    chk("b2b.c5.rs1", m_rs1, 9);
    cyc();
    chk("b2b.c6.ready", 32'(pcpi_ready), 1);
    chk("b2b.c6.rd", pcpi_rd, 3);
    pcpi_valid = 1'b0;
    unit_idle();
    repeat (3) cyc();
    chk("b2b.nissue", n_mup, 2);
    chk("b2b.nrdy", n_rdy, 2);

    // async reset mid-BUSY
    issue(MUL, 4, 4);
    cyc();
    cyc();
    chk("rb.c2.wait", 32'(pcpi_wait), 1);
    #2;
    resetn = 1'b0;
    #1;
    zero_chk("rmid");
    pcpi_valid = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    chk("rb.idle.wait", 32'(pcpi_wait), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
